// File: rtl/rv32_dec_pkg.sv
// Shared constants, buffer state type and the RV32I OP/OP-IMM legality check
// used by the decode stage.
package rv32_dec_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    // Only OP and OP-IMM encodings are decoded; anything else is illegal.
    function automatic logic is_legal(input logic [31:0] word);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        opc = word[6:0];
        f3  = word[14:12];
        f7  = word[31:25];
        ok  = 1'b0;
        if (opc == OPC_OP) begin
            ok = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end else if (opc == OPC_OP_IMM) begin
            case (f3)
                3'b001:  ok = (f7 == F7_BASE);
                3'b101:  ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                default: ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready buffer with a registered ready.
// head_q is always the presented entry; tail_q holds the second entry when FULL.
//
//   state | meaning
//   EMPTY | no entry held, out_valid=0
//   ONE   | head_q presented, tail_q unused
//   FULL  | head_q presented, tail_q queued behind it, no accept
//
// hold_next lets the owner force ready low from the next cycle on.
import rv32_dec_pkg::*;

module dec_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         hold_next,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;
    logic         consume;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    // Next-state, entry movement and next ready value.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    head_d = in_data;
                end else if (accept) begin
                    tail_d  = in_data;
                    state_d = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL) && !hold_next;
    end

    // State and entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I OP/OP-IMM decode stage: legality check, illegal-word handling,
// saturating illegal counter, 2-entry buffer towards the ALU stage.
// DEC_ILLEGAL_TRAP_EN: when defined, illegal words pass through flagged and
// halt intake until flush/rst; otherwise they are replaced by a NOP.
import rv32_dec_pkg::*;

module rv32_decode_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [WIDTH-1:0]     pc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6:0]           opcode,
    output logic [4:0]           rd_addr,
    output logic [2:0]           Funct3,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    output logic [6:0]           Funct7,
    output logic [11:0]          Imm_reg,
    output logic [4:0]           Shamt,
    output logic [WIDTH-1:0]     pc_out,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);

    localparam int PW = 1 + WIDTH + 32;

    logic                 in_legal;
    logic                 accept;
    logic [31:0]          enq_instr;
    logic                 enq_illegal;
    logic                 halt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]        head_data;
    logic [31:0]          head_instr;

    assign in_legal = is_legal(instr);
    assign accept   = in_valid & in_ready;

`ifdef DEC_ILLEGAL_TRAP_EN
    logic halt_q;

    assign enq_instr   = instr;
    assign enq_illegal = ~in_legal;

    // Halt latches on accepting an illegal word; only flush releases it.
    always_comb begin
        halt_d = halt_q;
        if (flush) begin
            halt_d = 1'b0;
        end else if (accept && !in_legal) begin
            halt_d = 1'b1;
        end
    end

    // Halt register.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`else
    assign enq_instr   = in_legal ? instr : NOP_INSTR;
    assign enq_illegal = 1'b0;
    assign halt_d      = 1'b0;
`endif

    // Count accepted illegal words, saturating; words dropped by flush are not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (!flush && accept && !in_legal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    dec_skid_buf #(
        .W (PW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold_next (halt_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({enq_illegal, pc_in, enq_instr}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_data)
    );

    assign head_instr  = head_data[31:0];
    assign pc_out      = head_data[WIDTH+31:32];
    assign illegal     = head_data[PW-1];
    assign opcode      = head_instr[6:0];
    assign rd_addr     = head_instr[11:7];
    assign Funct3      = head_instr[14:12];
    assign rs1_addr    = head_instr[19:15];
    assign rs2_addr    = head_instr[24:20];
    assign Funct7      = head_instr[31:25];
    assign Shamt       = head_instr[24:20];
    assign Imm_reg     = (head_instr[6:0] == OPC_OP) ? 12'h000 : head_instr[31:20];
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: queue-based reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_rv32_decode_stage;

`ifdef DEC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, illegal;
    logic [31:0] instr, pc_in, pc_out;
    logic [6:0]  opcode, Funct7;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr, Shamt;
    logic [2:0]  Funct3;
    logic [11:0] Imm_reg;
    logic [15:0] illegal_cnt;

    always #5 clk = ~clk;

    rv32_decode_stage #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd_addr(rd_addr), .Funct3(Funct3), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .Funct7(Funct7), .Imm_reg(Imm_reg), .Shamt(Shamt),
        .pc_out(pc_out), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        bit          ill;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    bit          m_ready = 1'b1;
    bit          m_halt = 1'b0;
    int unsigned m_cnt = 0;
    bit          m_acc_last = 1'b0;
    bit          acc, cons, lg;
    logic [31:0] w;
    logic [31:0] obs_pc[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_word(input logic [31:0] x);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = x[6:0];
        f3 = x[14:12];
        f7 = x[31:25];
        if (op == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (op == 7'h13) begin
            if (f3 == 3'd1) return f7 == 7'h00;
            if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model: FIFO of decoded words, updated at each rising edge.
    always @(posedge clk) begin
        m_acc_last = 1'b0;
        if (rst) begin
            q.delete();
            m_ready = 1'b1;
            m_halt  = 1'b0;
            m_cnt   = 0;
        end else if (flush) begin
            q.delete();
            m_halt  = 1'b0;
            m_ready = 1'b1;
        end else begin
            acc  = in_valid && m_ready;
            cons = (q.size() > 0) && out_ready;
            if (cons) begin
                obs_pc.push_back(pc_out);
                void'(q.pop_front());
            end
            if (acc) begin
                w  = instr;
                lg = legal_word(w);
                if (!lg && !TRAP) w = 32'h00000013;
                q.push_back('{w, pc_in, TRAP && !lg});
                if (!lg && m_cnt < 65535) m_cnt++;
                if (TRAP && !lg) m_halt = 1'b1;
                m_acc_last = 1'b1;
            end
            m_ready = (q.size() < 2) && !m_halt;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("illegal_cnt", 32'(illegal_cnt), m_cnt);
        if (q.size() > 0) begin
            e = q[0];
            check("opcode", 32'(opcode), 32'(e.word[6:0]));
            check("rd_addr", 32'(rd_addr), 32'(e.word[11:7]));
            check("Funct3", 32'(Funct3), 32'(e.word[14:12]));
            check("rs1_addr", 32'(rs1_addr), 32'(e.word[19:15]));
            check("rs2_addr", 32'(rs2_addr), 32'(e.word[24:20]));
            check("Funct7", 32'(Funct7), 32'(e.word[31:25]));
            check("Shamt", 32'(Shamt), 32'(e.word[24:20]));
            check("Imm_reg", 32'(Imm_reg), (e.word[6:0] == 7'h33) ? 32'd0 : 32'(e.word[31:20]));
            check("pc_out", pc_out, e.pc);
            check("illegal", 32'(illegal), 32'(e.ill));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [31:0] words[3];
    int          idx;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; pc_in = 32'h0;
        cyc(); cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_imm", 32'(Imm_reg), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_cnt", 32'(illegal_cnt), 32'd0);
        rst = 1'b0;
        cyc();

        // addi x1,x0,5 streamed at full rate
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00500093;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'h1000 + 32'(4 * i);
            cyc();
            check("addi_valid", 32'(out_valid), 32'd1);
            check("addi_pc", pc_out, 32'h1000 + 32'(4 * i));
            check("addi_in_ready", 32'(in_ready), 32'd1);
        end
        check("addi_opcode", 32'(opcode), 32'h13);
        check("addi_rd", 32'(rd_addr), 32'd1);
        check("addi_f3", 32'(Funct3), 32'd0);
        check("addi_imm", 32'(Imm_reg), 32'h005);
        in_valid = 1'b0;
        cyc();

        // add then sub
        in_valid = 1'b1; instr = 32'h002081B3; pc_in = 32'h2000;
        cyc();
        check("add_f7", 32'(Funct7), 32'h00);
        check("add_rs1", 32'(rs1_addr), 32'd1);
        check("add_rs2", 32'(rs2_addr), 32'd2);
        check("add_rd", 32'(rd_addr), 32'd3);
        check("add_imm", 32'(Imm_reg), 32'd0);
        instr = 32'h402081B3; pc_in = 32'h2004;
        cyc();
        check("sub_f7", 32'(Funct7), 32'h20);
        check("sub_opcode", 32'(opcode), 32'h33);
        check("sub_imm", 32'(Imm_reg), 32'd0);
        in_valid = 1'b0;
        cyc();

        // back-pressure: three words, two fit
        words[0] = 32'h00100093; words[1] = 32'h00200093; words[2] = 32'h00300093;
        out_ready = 1'b0; idx = 0;
        for (int n = 0; n < 6; n++) begin
            in_valid = 1'b1; instr = words[idx]; pc_in = 32'h3000 + 32'(4 * idx);
            cyc();
            if (m_acc_last) idx++;
        end
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_accepted", 32'(idx), 32'd2);
        obs_pc.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 10 && idx < 3; n++) begin
            in_valid = 1'b1; instr = words[idx]; pc_in = 32'h3000 + 32'(4 * idx);
            cyc();
            if (m_acc_last) idx++;
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        check("bp_drained", 32'(obs_pc.size()), 32'd3);
        for (int k = 0; k < 3 && k < obs_pc.size(); k++)
            check("bp_order", obs_pc[k], 32'h3000 + 32'(4 * k));

        // illegal sll
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h402091B3; pc_in = 32'h4000;
        cyc();
        in_valid = 1'b0;
        check("ill_cnt", 32'(illegal_cnt), 32'd1);
        if (TRAP) begin
            check("trap_illegal", 32'(illegal), 32'd1);
            check("trap_opcode", 32'(opcode), 32'h33);
            check("trap_f7", 32'(Funct7), 32'h20);
            out_ready = 1'b1;
            for (int n = 0; n < 3; n++) begin
                cyc();
                check("trap_halt_ready", 32'(in_ready), 32'd0);
            end
            flush = 1'b1;
            cyc();
            flush = 1'b0;
            check("trap_release", 32'(in_ready), 32'd1);
        end else begin
            check("nop_opcode", 32'(opcode), 32'h13);
            check("nop_rd", 32'(rd_addr), 32'd0);
            check("nop_rs1", 32'(rs1_addr), 32'd0);
            check("nop_f7", 32'(Funct7), 32'd0);
            check("nop_imm", 32'(Imm_reg), 32'd0);
            check("nop_illegal", 32'(illegal), 32'd0);
            out_ready = 1'b1;
            cyc();
        end

        // flush of a full buffer, then flush while a word is accepted
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100093; pc_in = 32'h5000;
        cyc();
        pc_in = 32'h5004;
        cyc();
        check("full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; instr = 32'h402091B3;
        cyc();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_cnt", 32'(illegal_cnt), 32'd1);
        cyc();
        check("flush_acc_valid", 32'(out_valid), 32'd0);
        check("flush_acc_ready", 32'(in_ready), 32'd1);
        check("flush_acc_cnt", 32'(illegal_cnt), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        cyc();

        // reset in the middle of a transfer
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00700093; pc_in = 32'h6000;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_cnt", 32'(illegal_cnt), 32'd0);
        cyc();

        // counter saturation
        if (!TRAP) begin
            out_ready = 1'b1; in_valid = 1'b1; instr = 32'h402091B3; pc_in = 32'h7000;
            repeat (65534) cyc();
            check("sat_fffe", 32'(illegal_cnt), 32'h0000FFFE);
            repeat (5) cyc();
            in_valid = 1'b0;
            cyc();
            check("sat_ffff", 32'(illegal_cnt), 32'h0000FFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
